// File: rtl/flag_ccr_if.sv
// Pipeline-side bundle for the condition-code unit: ALU flag writes, jump
// evaluation and interrupt save/restore, plus the resulting CCR status.
interface flag_ccr_if #(
    parameter int PW = 2
);
    logic          stall;
    logic [2:0]    alu_flags;
    logic [2:0]    flag_we;
    logic          jmp_valid;
    logic [1:0]    jmp_cond;
    logic          int_save;
    logic          rti_restore;
    logic [15:0]   flags;
    logic          jmp_taken;
    logic [PW-1:0] stk_depth;
    logic          stk_ovf;
    logic          stk_unf;

    modport master (
        output stall, alu_flags, flag_we, jmp_valid, jmp_cond, int_save, rti_restore,
        input  flags, jmp_taken, stk_depth, stk_ovf, stk_unf
    );

    modport slave (
        input  stall, alu_flags, flag_we, jmp_valid, jmp_cond, int_save, rti_restore,
        output flags, jmp_taken, stk_depth, stk_ovf, stk_unf
    );
endinterface

// File: rtl/flag_ccr_unit.sv
// Z/N/C condition-code register with conditional-jump evaluation and a LIFO
// shadow stack that preserves flags across nested interrupts.
module flag_ccr_unit #(
    parameter int DEPTH = 2,
    parameter int PW    = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    flag_ccr_if.slave bus
);
    logic [2:0]    ccr_reg, ccr_next;
    logic [PW-1:0] ptr_reg, ptr_next;
    logic [2:0]    stack_reg [DEPTH];
    logic          ovf_reg, ovf_next;
    logic          unf_reg, unf_next;

    logic          full, empty;
    logic          pop_ok, push_ok;
    logic          taken;
    logic [2:0]    clr_mask;
    logic [2:0]    pop_data;
    logic [2:0]    hit_data [DEPTH];

    assign full  = (ptr_reg == PW'(DEPTH));
    assign empty = (ptr_reg == '0);

    // Jump decision uses only the registered CCR; same-cycle ALU results are not bypassed.
    always_comb begin
        taken    = 1'b0;
        clr_mask = 3'b000;
        if (bus.jmp_valid && !bus.stall) begin
            case (bus.jmp_cond)
                2'b00:   begin taken = ccr_reg[0]; clr_mask = {2'b00, ccr_reg[0]}; end
                2'b01:   begin taken = ccr_reg[1]; clr_mask = {1'b0, ccr_reg[1], 1'b0}; end
                2'b10:   begin taken = ccr_reg[2]; clr_mask = {ccr_reg[2], 2'b00}; end
                default: begin taken = 1'b1;       clr_mask = 3'b000; end
            endcase
        end
    end

    assign pop_ok  = !bus.stall && bus.rti_restore && !empty;
    assign push_ok = !bus.stall && bus.int_save && !bus.rti_restore && !full;

    // Top-of-stack select: entry gi is the top when ptr == gi+1.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_top
            assign hit_data[gi] = (ptr_reg == PW'(gi + 1)) ? stack_reg[gi] : 3'b000;
        end
    endgenerate

    always_comb begin
        pop_data = 3'b000;
        for (int i = 0; i < DEPTH; i++) begin
            pop_data = pop_data | hit_data[i];
        end
    end

    // Per-bit priority: restore, then ALU write, then jump clear, then hold.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ccr
            always_comb begin
                ccr_next[gi] = ccr_reg[gi];
                if (bus.stall)
                    ccr_next[gi] = ccr_reg[gi];
                else if (pop_ok)
                    ccr_next[gi] = pop_data[gi];
                else if (bus.flag_we[gi])
                    ccr_next[gi] = bus.alu_flags[gi];
                else if (clr_mask[gi])
                    ccr_next[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        ptr_next = ptr_reg;
        if (pop_ok)
            ptr_next = ptr_reg - 1'b1;
        else if (push_ok)
            ptr_next = ptr_reg + 1'b1;
    end

    // A push alongside a restore is a protocol error and is reported as overflow.
    assign ovf_next = ovf_reg | (!bus.stall && bus.int_save && (bus.rti_restore || full));
    assign unf_next = unf_reg | (!bus.stall && bus.rti_restore && empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ccr_reg <= 3'b000;
            ptr_reg <= '0;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack_reg[i] <= 3'b000;
        end else begin
            ccr_reg <= ccr_next;
            ptr_reg <= ptr_next;
            ovf_reg <= ovf_next;
            unf_reg <= unf_next;
            for (int i = 0; i < DEPTH; i++) begin
                if (push_ok && ptr_reg == PW'(i)) stack_reg[i] <= ccr_reg;
            end
        end
    end

    assign bus.flags     = {13'b0, ccr_reg};
    assign bus.jmp_taken = taken;
    assign bus.stk_depth = ptr_reg;
    assign bus.stk_ovf   = ovf_reg;
    assign bus.stk_unf   = unf_reg;
endmodule

// File: tb/tb_flag_ccr_unit.sv
// Directed bench for flag_ccr_unit: a queue-based flag model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_flag_ccr_unit;
    localparam int DEPTH = 2;
    localparam int PW    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    flag_ccr_if #(.PW(PW)) bus ();

    flag_ccr_unit #(.DEPTH(DEPTH), .PW(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Behavioural model: flags as three bits, shadow stack as a queue.
    logic [2:0] m_ccr;
    logic [2:0] m_stack[$];
    logic       m_ovf, m_unf;

    function automatic logic model_taken();
        if (!bus.jmp_valid || bus.stall) return 1'b0;
        if (bus.jmp_cond == 2'b11) return 1'b1;
        return m_ccr[bus.jmp_cond];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ccr = 3'b000;
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!bus.stall) begin
            logic [2:0] old_ccr;
            logic       tk;
            old_ccr = m_ccr;
            tk = model_taken();
            if (bus.int_save && (bus.rti_restore || m_stack.size() == DEPTH)) m_ovf = 1'b1;
            if (bus.rti_restore && m_stack.size() > 0) begin
                m_ccr = m_stack.pop_back();
            end else begin
                if (bus.rti_restore) m_unf = 1'b1;
                if (bus.int_save && !bus.rti_restore && m_stack.size() < DEPTH)
                    m_stack.push_back(old_ccr);
                if (tk && bus.jmp_cond != 2'b11) m_ccr[bus.jmp_cond] = 1'b0;
                for (int b = 0; b < 3; b++)
                    if (bus.flag_we[b]) m_ccr[b] = bus.alu_flags[b];
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, half a period after the edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("model_flags", bus.flags, {13'b0, m_ccr});
            check("model_taken", {15'b0, bus.jmp_taken}, {15'b0, model_taken()});
            check("model_depth", {14'b0, bus.stk_depth}, 16'(m_stack.size()));
            check("model_ovf", {15'b0, bus.stk_ovf}, {15'b0, m_ovf});
            check("model_unf", {15'b0, bus.stk_unf}, {15'b0, m_unf});
        end
    end

    task automatic drive(input logic st, input logic [2:0] af, input logic [2:0] we,
                         input logic jv, input logic [1:0] jc, input logic is, input logic rr);
        bus.stall       = st;
        bus.alu_flags   = af;
        bus.flag_we     = we;
        bus.jmp_valid   = jv;
        bus.jmp_cond    = jc;
        bus.int_save    = is;
        bus.rti_restore = rr;
    endtask

    task automatic idle();
        drive(1'b0, 3'b000, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of stimulus, let it take effect, then return to idle inputs.
    task automatic step(input logic st, input logic [2:0] af, input logic [2:0] we,
                        input logic jv, input logic [1:0] jc, input logic is, input logic rr,
                        input string tag);
        drive(st, af, we, jv, jc, is, rr);
        tick();
        idle();
        $display("[TB] %s -> flags=%h depth=%0d ovf=%b unf=%b", tag, bus.flags,
                 bus.stk_depth, bus.stk_ovf, bus.stk_unf);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #2;
        check("reset_flags", bus.flags, 16'h0000);
        check("reset_depth", {14'b0, bus.stk_depth}, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ALU writes
        step(0, 3'b101, 3'b001, 0, 2'b00, 0, 0, "alu we=001");
        check("alu_z", bus.flags, 16'h0001);
        step(0, 3'b010, 3'b110, 0, 2'b00, 0, 0, "alu we=110");
        check("alu_nc", bus.flags, 16'h0003);

        // JZ taken, clears Z
        drive(0, 3'b000, 3'b000, 1, 2'b00, 0, 0);
        #1 check("jz_taken", {15'b0, bus.jmp_taken}, 16'h0001);
        tick(); idle();
        $display("[TB] jz -> flags=%h", bus.flags);
        check("jz_clear", bus.flags, 16'h0002);

        // JZ with simultaneous Z write: write wins
        step(0, 3'b001, 3'b001, 0, 2'b00, 0, 0, "set z");
        drive(0, 3'b001, 3'b001, 1, 2'b00, 0, 0);
        #1 check("jz2_taken", {15'b0, bus.jmp_taken}, 16'h0001);
        tick(); idle();
        $display("[TB] jz+write -> flags=%h", bus.flags);
        check("jz_write_wins", bus.flags, 16'h0003);

        // JMP with CCR=0
        step(0, 3'b000, 3'b111, 0, 2'b00, 0, 0, "clear all");
        check("clear_all", bus.flags, 16'h0000);
        drive(0, 3'b000, 3'b000, 1, 2'b11, 0, 0);
        #1 check("jmp_taken", {15'b0, bus.jmp_taken}, 16'h0001);
        tick(); idle();
        $display("[TB] jmp -> flags=%h", bus.flags);
        check("jmp_nochange", bus.flags, 16'h0000);

        // Nesting
        step(0, 3'b100, 3'b111, 0, 2'b00, 0, 0, "ccr=100");
        step(0, 3'b000, 3'b000, 0, 2'b00, 1, 0, "save1");
        check("nest_d1", {14'b0, bus.stk_depth}, 16'd1);
        step(0, 3'b010, 3'b111, 0, 2'b00, 0, 0, "ccr=010");
        step(0, 3'b000, 3'b000, 0, 2'b00, 1, 0, "save2");
        check("nest_d2", {14'b0, bus.stk_depth}, 16'd2);
        step(0, 3'b000, 3'b000, 0, 2'b00, 1, 0, "save3 full");
        check("nest_ovf", {15'b0, bus.stk_ovf}, 16'd1);
        check("nest_d2_hold", {14'b0, bus.stk_depth}, 16'd2);
        step(0, 3'b000, 3'b000, 0, 2'b00, 0, 1, "rti1");
        check("rti1_flags", bus.flags, 16'h0002);
        step(0, 3'b000, 3'b000, 0, 2'b00, 0, 1, "rti2");
        check("rti2_flags", bus.flags, 16'h0004);
        step(0, 3'b000, 3'b000, 0, 2'b00, 0, 1, "rti3 empty");
        check("rti3_unf", {15'b0, bus.stk_unf}, 16'd1);
        check("rti3_flags", bus.flags, 16'h0004);
        step(0, 3'b010, 3'b111, 0, 2'b00, 0, 1, "rti empty + alu");
        check("unf_alu_applies", bus.flags, 16'h0002);

        // Mid-operation asynchronous reset with CCR=111, depth=1
        step(0, 3'b111, 3'b111, 0, 2'b00, 0, 0, "ccr=111");
        step(0, 3'b000, 3'b000, 0, 2'b00, 1, 0, "save");
        check("pre_rst_depth", {14'b0, bus.stk_depth}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_flags", bus.flags, 16'h0000);
        check("arst_depth", {14'b0, bus.stk_depth}, 16'd0);
        check("arst_ovf", {15'b0, bus.stk_ovf}, 16'd0);
        check("arst_unf", {15'b0, bus.stk_unf}, 16'd0);
        tick();
        rst_n = 1'b1;

        // Push pre-update value while ALU writes, then simultaneous save+restore
        step(0, 3'b001, 3'b111, 0, 2'b00, 0, 0, "ccr=001");
        step(0, 3'b110, 3'b111, 0, 2'b00, 1, 0, "save + alu");
        check("push_alu_flags", bus.flags, 16'h0006);
        check("push_alu_depth", {14'b0, bus.stk_depth}, 16'd1);
        step(0, 3'b110, 3'b111, 0, 2'b00, 1, 1, "save+rti");
        check("sim_flags", bus.flags, 16'h0001);
        check("sim_depth", {14'b0, bus.stk_depth}, 16'd0);
        check("sim_ovf", {15'b0, bus.stk_ovf}, 16'd1);

        // Stall holds everything
        drive(1, 3'b110, 3'b111, 1, 2'b00, 1, 0);
        #1 check("stall_taken", {15'b0, bus.jmp_taken}, 16'h0000);
        tick(); idle();
        $display("[TB] stall -> flags=%h depth=%0d", bus.flags, bus.stk_depth);
        check("stall_flags", bus.flags, 16'h0001);
        check("stall_depth", {14'b0, bus.stk_depth}, 16'd0);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/flag_ccr_unit.md
Name: flag_ccr_unit

Overview:
- Condition-code register (CCR) that holds the Z/N/C flags produced by the execute-stage ALU.
- Evaluates conditional jumps (JZ/JN/JC/JMP) against the held flags and clears the tested flag when a jump is taken.
- Saves and restores flags across interrupts through a small LIFO shadow stack, so nested interrupts are supported.
- Sits between the execute stage and the branch/PC logic of the five-stage pipeline.

Parameters:
- DEPTH, 2: shadow-stack entries, i.e. maximum interrupt nesting (>=1).
- PW, 2: stack pointer width; must equal $clog2(DEPTH+1).

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  1 = hold all state, suppress jmp_taken.
- alu_flags  input  3  ALU flag result, {C,N,Z} = bits [2:0].
- flag_we  input  3  per-flag write enable for alu_flags (bit i enables flag i).
- jmp_valid  input  1  a jump instruction is in the evaluate slot.
- jmp_cond  input  2  00 JZ, 01 JN, 10 JC, 11 JMP (unconditional).
- int_save  input  1  interrupt entry: push flags onto the shadow stack.
- rti_restore  input  1  RTI: pop the shadow stack into the flags.
- flags  output  16  {13'b0, C, N, Z} from the registered CCR.
- jmp_taken  output  1  combinational jump decision.
- stk_depth  output  PW  number of occupied stack entries.
- stk_ovf  output  1  sticky: a push was attempted while the stack was full.
- stk_unf  output  1  sticky: a pop was attempted while the stack was empty.

Behaviour:
- Reset (rst_n=0, asynchronous): CCR=3'b000; stack pointer=0; stack contents=0; stk_ovf=0; stk_unf=0; outputs take these values immediately.
- jmp_taken (combinational from registered CCR, no ALU bypass): jmp_valid & ~stall & (JZ:Z | JN:N | JC:C | JMP:1).
- Next-state priority when stall=0:
  1. rti_restore, stack not empty: pop; CCR <= stack[ptr-1]; ptr--. This overrides ALU writes and jump clears in the same cycle.
  2. rti_restore, stack empty: CCR unchanged by the pop; stk_unf <= 1; ALU writes and jump clears still apply.
  3. int_save without rti_restore: push the pre-update CCR value; ptr++. ALU writes and jump clears still apply to the CCR in the same cycle.
  4. int_save while full (ptr==DEPTH): push dropped; stk_ovf <= 1; ptr unchanged.
  5. int_save and rti_restore together: the restore is performed as above, the push is ignored, and stk_ovf <= 1 (flags the protocol error).
- CCR per-bit update when no successful pop occurs:
  - flag_we[i]=1: CCR[i] <= alu_flags[i].
  - else if a taken JZ/JN/JC tests bit i: CCR[i] <= 0.
  - else CCR[i] holds.
  - JMP clears nothing.
  - An ALU write wins over a jump clear on the same bit.
- stall=1: CCR, stack, ptr and sticky bits all hold; jmp_taken=0; int_save and rti_restore are ignored (the pipeline re-presents them).
- Latency:
  - Flags written in cycle n are visible on flags in cycle n+1.
  - A jump in cycle n+1 sees them; a jump in cycle n does not.
- Sticky bits clear only on reset.
- ptr never wraps; it saturates at 0 and DEPTH.

Test Plan:
- Reset: rst_n=0 mid-operation with CCR=3'b111 and ptr=1 -> flags=16'h0000, stk_depth=0, stk_ovf=stk_unf=0 asynchronously, before the next clock edge.
- ALU write: alu_flags=3'b101, flag_we=3'b001 -> next cycle flags=16'h0001; then flag_we=3'b110 with alu_flags=3'b010 -> flags=16'h0003.
- Jump: CCR Z=1, jmp_valid=1, jmp_cond=00 -> jmp_taken=1 same cycle, Z=0 next cycle. Repeat with a simultaneous flag_we[0]=1, alu_flags[0]=1 -> Z stays 1. JMP with CCR=0 -> taken=1, CCR unchanged.
- Nesting (DEPTH=2):
  - CCR=3'b100, int_save -> depth=1.
  - Set CCR=3'b010, int_save -> depth=2.
  - Third int_save -> stk_ovf=1, depth=2.
  - rti_restore -> flags=16'h0002; rti_restore again -> flags=16'h0004; third rti_restore -> stk_unf=1, flags stay 16'h0004.
- Simultaneous: depth=1 holding 3'b001, int_save=rti_restore=1, flag_we=3'b111 with alu_flags=3'b110 -> flags=16'h0001, depth=0, stk_ovf=1.
- Stall: stall=1 with flag_we=3'b111, int_save=1, jmp_valid=1 and a true condition -> jmp_taken=0; flags and depth unchanged after the edge.
